fetch_sequencer: RTL and testbench

Instruction fetch and program-counter controller for the accumulator CPU. It fetches 16-bit words from instruction memory over a request/acknowledge handshake and presents each word to the instruction decoder for exactly one cycle. One cycle later it reads back the decoder's registered `jmpEnable`/`branchEnable`/`jmpDir`/`branchDir` and selects the next fetch address. It sits between instruction memory and the decoder and sequences the whole datapath, one instruction at a time.

---
 rtl/fetch_sequencer_pkg.sv | 33 +++
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_fetch_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the accumulator CPU front end: opcodes, the NOP
// instruction word and the fetch sequencer state encoding.
package fetch_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_STA = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_XOR = 4'h7,
    OP_NOT = 4'h8,
    OP_SHL = 4'h9,
    OP_SHR = 4'hA,
    OP_JMP = 4'hB,
    OP_BZ  = 4'hC,
    OP_BC  = 4'hD,
    OP_IN  = 4'hE,
    OP_OUT = 4'hF
  } opcode_e;

  localparam logic [15:0] NOP_INSTR = {OP_NOP, 12'h000};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_RESOLVE = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch / program-counter controller: fetches one word over a
// req/ack handshake, issues it for one cycle, then picks the next address.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              PC_W     = 10,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  input  logic               jmpEnable,
  input  logic               branchEnable,
  input  logic [9:0]         jmpDir,
  input  logic [5:0]         branchDir
);

  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

  state_e               r_state;
  logic [PC_W-1:0]      r_fetch_pc;
  logic [PC_W-1:0]      r_pc;
  logic [INSTR_W-1:0]   r_instr;
  logic                 r_instr_valid;
  logic                 r_imem_req;
  logic                 r_busy;

  state_e               w_state_nxt;
  logic [PC_W-1:0]      w_fetch_pc_nxt;
  logic [PC_W-1:0]      w_pc_nxt;
  logic [INSTR_W-1:0]   w_instr_nxt;
  logic                 w_instr_valid_nxt;
  logic                 w_imem_req_nxt;
  logic signed [5:0]    w_boff;
  logic [PC_W-1:0]      w_branch_pc;
  logic [PC_W-1:0]      w_target_pc;

  // Branch offset is sign-extended to PC width; the sum wraps silently.
  assign w_boff      = branchDir;
  assign w_branch_pc = r_pc + PC_W'(w_boff);

  always_comb begin
    w_target_pc = r_pc + PC_W'(1);
    if (jmpEnable) begin
      w_target_pc = PC_W'(jmpDir);
    end else if (branchEnable) begin
      w_target_pc = w_branch_pc;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_pc_nxt          = r_pc;
    w_instr_nxt       = NOP_W;
    w_instr_valid_nxt = 1'b0;
    w_imem_req_nxt    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_state_nxt    = ST_FETCH;
          w_imem_req_nxt = 1'b1;
        end
      end
      ST_FETCH: begin
        w_imem_req_nxt = 1'b1;
        if (imem_ack) begin
          w_state_nxt       = ST_ISSUE;
          w_instr_nxt       = imem_data;
          w_pc_nxt          = r_fetch_pc;
          w_instr_valid_nxt = 1'b1;
          w_imem_req_nxt    = 1'b0;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        // Decoder outputs are registered, so they describe the issued word now.
        w_fetch_pc_nxt = w_target_pc;
        w_state_nxt    = run ? ST_FETCH : ST_IDLE;
        w_imem_req_nxt = run;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_W;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_imem_req    <= w_imem_req_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_fetch_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign busy        = r_busy;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a driver plays directed fetch steps,
// a monitor checks every issued instruction against the queued expectation.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic [9:0]  pc;
  logic        busy;
  logic        jmpEnable;
  logic        branchEnable;
  logic [9:0]  jmpDir;
  logic [5:0]  branchDir;

  fetch_sequencer #(.PC_W(10), .INSTR_W(16), .RESET_PC(10'h000)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .busy         (busy),
    .jmpEnable    (jmpEnable),
    .branchEnable (branchEnable),
    .jmpDir       (jmpDir),
    .branchDir    (branchDir)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  pc;
    logic [15:0] instr;
    int          gap;
  } exp_t;

  typedef struct {
    logic [9:0] addr;
    int         dly;
    bit         tie;
    bit         jmp;
    bit         br;
    logic [9:0] jdir;
    logic [5:0] bdir;
    bit         drop;
    int         gap;
  } step_t;

  exp_t  sb[$];
  exp_t  mon_e;
  step_t steps[13];
  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    last_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic step_t mk(input logic [9:0] addr, input int dly, input bit tie,
                               input bit jmp, input bit br, input logic [9:0] jdir,
                               input logic [5:0] bdir, input bit drop, input int gap);
    step_t s;
    s.addr = addr; s.dly = dly; s.tie = tie; s.jmp = jmp; s.br = br;
    s.jdir = jdir; s.bdir = bdir; s.drop = drop; s.gap = gap;
    return s;
  endfunction

  function automatic logic [15:0] word_at(input logic [9:0] a);
    return {6'b101000, a};
  endfunction

  // Decoder values outside RESOLVE are junk that the DUT must ignore.
  task automatic noise();
    jmpEnable = 1'b1; branchEnable = 1'b1; jmpDir = 10'h155; branchDir = 6'h15;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (instr_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_underflow: got unexpected issue pc=0x%0h, required none", pc);
      end else begin
        mon_e = sb.pop_front();
        chk("issue_pc", 32'(pc), 32'(mon_e.pc));
        chk("issue_instr", 32'(instr), 32'(mon_e.instr));
        if (mon_e.gap != 0) chk("issue_gap", cyc - last_cyc, mon_e.gap);
      end
      last_cyc = cyc;
    end
  end

  task automatic run_step(input int k);
    step_t s;
    exp_t  e;
    int    t;
    s   = steps[k];
    run = 1'b1;
    t   = 0;
    while (!imem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("req_seen", 32'(imem_req), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(s.addr));
    e.pc = s.addr; e.instr = word_at(s.addr); e.gap = s.gap;
    sb.push_back(e);
    if (s.drop) run = 1'b0;
    if (s.dly > 0) begin
      imem_ack  = 1'b0;
      imem_data = 16'hBAD0;
      for (int i = 0; i < s.dly; i++) begin
        @(negedge clk);
        chk("wait_req", 32'(imem_req), 32'd1);
        chk("wait_addr", 32'(imem_addr), 32'(s.addr));
      end
    end
    imem_data = word_at(s.addr);
    imem_ack  = 1'b1;
    @(negedge clk);
    imem_data = 16'hDEAD;
    if (!s.tie) imem_ack = 1'b0;
    jmpEnable = s.jmp; branchEnable = s.br; jmpDir = s.jdir; branchDir = s.bdir;
    @(negedge clk);
    @(negedge clk);
    noise();
    if (s.drop) begin
      chk("stop_req", 32'(imem_req), 32'd0);
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_valid", 32'(instr_valid), 32'd0);
      repeat (2) @(negedge clk);
      chk("idle_req", 32'(imem_req), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                addr  dly tie jmp br  jdir     bdir   drop gap
    steps[0]  = mk(10'h000, 0, 1, 0, 0, 10'h000, 6'h00, 0, 0);
    steps[1]  = mk(10'h001, 0, 1, 0, 0, 10'h000, 6'h00, 0, 3);
    steps[2]  = mk(10'h002, 0, 1, 0, 0, 10'h000, 6'h00, 0, 3);
    steps[3]  = mk(10'h003, 0, 0, 0, 0, 10'h000, 6'h00, 0, 3);
    steps[4]  = mk(10'h004, 0, 0, 0, 0, 10'h000, 6'h00, 0, 3);
    steps[5]  = mk(10'h005, 0, 0, 1, 1, 10'h200, 6'h01, 0, 3);
    steps[6]  = mk(10'h200, 0, 0, 1, 0, 10'h003, 6'h00, 0, 3);
    steps[7]  = mk(10'h003, 0, 0, 0, 1, 10'h000, 6'h3E, 0, 3);
    steps[8]  = mk(10'h001, 0, 0, 0, 1, 10'h000, 6'h3E, 0, 3);
    steps[9]  = mk(10'h3FF, 0, 0, 0, 0, 10'h000, 6'h00, 0, 3);
    steps[10] = mk(10'h000, 4, 0, 0, 0, 10'h000, 6'h00, 1, 7);
    steps[11] = mk(10'h001, 1, 0, 0, 0, 10'h000, 6'h00, 0, 0);
    steps[12] = mk(10'h000, 0, 0, 0, 0, 10'h000, 6'h00, 1, 0);

    reset = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000;
    noise();
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h000);
    chk("rst_pc", 32'(pc), 32'h000);
    chk("rst_instr", 32'(instr), 32'h0000);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 12; k++) run_step(k);

    // Step 11 left the DUT fetching 0x002; pull reset between clock edges.
    chk("midrst_pre_req", 32'(imem_req), 32'd1);
    chk("midrst_pre_addr", 32'(imem_addr), 32'h002);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(imem_addr), 32'h000);
    chk("midrst_pc", 32'(pc), 32'h000);
    @(negedge clk);
    reset = 1'b1;

    run_step(12);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
